// File: rtl/ram_pkg.sv
// Shared types and byte-lane helpers for screen_ram and its fill engine.
// Helpers work on a 64-bit superset word; callers cast to their own width.
package ram_pkg;

  localparam int unsigned MaxWidth = 64;
  localparam int unsigned MaxBytes = MaxWidth / 8;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_RUN,
    FILL_DONE
  } fill_state_t;

  // Bytes with be=1 come from new_word, the rest keep old_word.
  function automatic logic [MaxWidth-1:0] byte_merge(input logic [MaxWidth-1:0] old_word,
                                                     input logic [MaxWidth-1:0] new_word,
                                                     input logic [MaxBytes-1:0] be);
    logic [MaxWidth-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(MaxBytes); i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  // Even parity per byte: the stored bit makes the byte plus parity bit even.
  function automatic logic [MaxBytes-1:0] byte_parity(input logic [MaxWidth-1:0] word);
    logic [MaxBytes-1:0] res;
    for (int i = 0; i < int'(MaxBytes); i++) begin
      res[i] = ^word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_fill_fsm.sv
// Screen fill engine: walks the screen window writing one latched word per cycle.
// A CPU write (stall_i) takes the array port; the fill holds its pointer that cycle.
module ram_fill_fsm
  import ram_pkg::*;
#(
  parameter int unsigned Width        = 16,
  parameter int unsigned AddrW        = 8,
  parameter int unsigned PtrW         = 6,
  parameter int unsigned ScreenOffset = 128,
  parameter int unsigned ScreenSize   = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fill_start_i,
  input  logic [Width-1:0] fill_value_i,
  input  logic             stall_i,
  output logic             fill_we_o,
  output logic [AddrW-1:0] fill_addr_o,
  output logic [Width-1:0] fill_wdata_o,
  output logic             fill_busy_o,
  output logic             fill_done_o
);

  localparam logic [AddrW-1:0] ScreenBase = AddrW'(ScreenOffset);
  localparam logic [PtrW-1:0]  LastPtr    = PtrW'(ScreenSize - 1);

  fill_state_t      state_q, state_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [Width-1:0] value_q, value_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL_IDLE;
      ptr_q   <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      value_q <= value_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    value_d = value_q;
    unique case (state_q)
      FILL_IDLE: begin
        if (fill_start_i) begin
          state_d = FILL_RUN;
          ptr_d   = '0;
          value_d = fill_value_i;
        end
      end
      FILL_RUN: begin
        if (!stall_i) begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == LastPtr) state_d = FILL_DONE;
        end
      end
      FILL_DONE: state_d = FILL_IDLE;
      default:   state_d = FILL_IDLE;
    endcase
  end

  always_comb begin
    fill_we_o    = (state_q == FILL_RUN) && !stall_i;
    fill_addr_o  = ScreenBase + AddrW'(ptr_q);
    fill_wdata_o = value_q;
    fill_busy_o  = (state_q == FILL_RUN);
    fill_done_o  = (state_q == FILL_DONE);
  end

endmodule

// File: rtl/screen_ram.sv
// CPU data RAM with a screen window: byte-writable CPU port, screen read port, fill engine.
// Define SCREEN_RAM_PARITY_EN to store per-byte even parity and add the parity_err output.
module screen_ram
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH             = 16,
  parameter int unsigned REGISTER_COUNT    = 256,
  parameter int unsigned RAM_SCREEN_OFFSET = 128,
  parameter int unsigned SCREEN_SIZE       = 64
) (
  input  logic                           cpu_clk,
  input  logic                           rst_n,
  input  logic [$clog2(REGISTER_COUNT)-1:0] addr,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           we,
  input  logic [WIDTH/8-1:0]             be,
  output logic [WIDTH-1:0]               rdata,
  input  logic [$clog2(SCREEN_SIZE)-1:0] addr_screen,
  output logic [WIDTH-1:0]               rdata_screen,
  input  logic                           fill_start,
  input  logic [WIDTH-1:0]               fill_value,
  output logic                           fill_busy,
  output logic                           fill_done
`ifdef SCREEN_RAM_PARITY_EN
  ,
  output logic                           parity_err
`endif
);

  localparam int unsigned AW = $clog2(REGISTER_COUNT);
  localparam int unsigned SW = $clog2(SCREEN_SIZE);
  localparam int unsigned NB = WIDTH / 8;

  localparam logic [AW-1:0] ScreenBase = AW'(RAM_SCREEN_OFFSET);

  logic [WIDTH-1:0] mem_q [REGISTER_COUNT];

  logic [WIDTH-1:0] cpu_old, cpu_merged;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] screen_q;
  logic [AW-1:0]    screen_addr;

  logic             fill_we;
  logic [AW-1:0]    fill_addr;
  logic [WIDTH-1:0] fill_wdata;

  ram_fill_fsm #(
    .Width       (WIDTH),
    .AddrW       (AW),
    .PtrW        (SW),
    .ScreenOffset(RAM_SCREEN_OFFSET),
    .ScreenSize  (SCREEN_SIZE)
  ) u_fill (
    .clk_i       (cpu_clk),
    .rst_ni      (rst_n),
    .fill_start_i(fill_start),
    .fill_value_i(fill_value),
    .stall_i     (we),
    .fill_we_o   (fill_we),
    .fill_addr_o (fill_addr),
    .fill_wdata_o(fill_wdata),
    .fill_busy_o (fill_busy),
    .fill_done_o (fill_done)
  );

  assign cpu_old     = mem_q[addr];
  assign cpu_merged  = WIDTH'(byte_merge(MaxWidth'(cpu_old), MaxWidth'(wdata), MaxBytes'(be)));
  assign rdata_d     = we ? cpu_merged : cpu_old;
  assign screen_addr = ScreenBase + AW'(addr_screen);

  // Array is not reset; fill_we is already suppressed by we, CPU wins regardless.
  always_ff @(posedge cpu_clk) begin
    if (we) begin
      mem_q[addr] <= cpu_merged;
    end else if (fill_we) begin
      mem_q[fill_addr] <= fill_wdata;
    end
  end

  // Screen read samples the array before this cycle's write lands (read-old).
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      screen_q <= '0;
    end else begin
      rdata_q  <= rdata_d;
      screen_q <= mem_q[screen_addr];
    end
  end

  assign rdata        = rdata_q;
  assign rdata_screen = screen_q;

`ifdef SCREEN_RAM_PARITY_EN
  logic [NB-1:0] par_q [REGISTER_COUNT];
  logic [NB-1:0] cpu_par_new, fill_par, cpu_par_bad, be_wr;
  logic          perr_q, perr_d;

  assign cpu_par_new = NB'(byte_parity(MaxWidth'(cpu_merged)));
  assign fill_par    = NB'(byte_parity(MaxWidth'(fill_wdata)));
  assign cpu_par_bad = NB'(byte_parity(MaxWidth'(cpu_old))) ^ par_q[addr];
  assign be_wr       = we ? be : '0;
  // Only bytes returned from storage are checked; freshly written bytes are fresh.
  assign perr_d      = |(cpu_par_bad & ~be_wr);

  always_ff @(posedge cpu_clk) begin
    if (we) begin
      par_q[addr] <= cpu_par_new;
    end else if (fill_we) begin
      par_q[fill_addr] <= fill_par;
    end
  end

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`endif

endmodule
